// File: rtl/cram_access_arbiter.sv
// cram_access_arbiter: shares the single cart-RAM byte port between the cpu, savestate (ss) and backup (bk) requesters
//   clk_sys, reset            : system clock, asynchronous active-high reset
//   {cpu,ss,bk}_req/we/addr/di : level request held until ack, direction, byte address, write data
//   {cpu,ss,bk}_do/ack         : read data (held until that requester's next read), one-cycle completion strobe
//   ss_lock                    : restricts grants to ss only
//   mem_addr/we/di, mem_q      : registered RAM address/write pulse/write data, RAM read data (1-cycle latency)
//   busy, grant                : transaction in flight, current owner (0 none, 1 cpu, 2 ss, 3 bk)
module cram_access_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int AGE_MAX = 15
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_di,
    output logic [7:0]        cpu_do,
    output logic              cpu_ack,
    input  logic              ss_req,
    input  logic              ss_we,
    input  logic [ADDR_W-1:0] ss_addr,
    input  logic [7:0]        ss_di,
    output logic [7:0]        ss_do,
    output logic              ss_ack,
    input  logic              bk_req,
    input  logic              bk_we,
    input  logic [ADDR_W-1:0] bk_addr,
    input  logic [7:0]        bk_di,
    output logic [7:0]        bk_do,
    output logic              bk_ack,
    input  logic              ss_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_di,
    input  logic [7:0]        mem_q,
    output logic              busy,
    output logic [1:0]        grant
);
    localparam int AW = AGE_MAX > 0 ? $clog2(AGE_MAX + 1) : 1;
    localparam logic [AW-1:0] AGE_TOP = AW'(AGE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            state, state_n;
    logic [1:0]        grant_n, win;
    logic [ADDR_W-1:0] addr_n;
    logic              we_n, wr, wr_n;
    logic [7:0]        di_n, cpu_do_n, ss_do_n, bk_do_n;
    logic [AW-1:0]     age, age_n;

    // bk jumps ahead of ss once it has aged out; cpu always stays on top
    assign win = (cpu_req && !ss_lock) ? 2'd1 :
                 (bk_req && !ss_lock && age == AGE_TOP) ? 2'd3 :
                 ss_req ? 2'd2 :
                 (bk_req && !ss_lock) ? 2'd3 : 2'd0;

    assign cpu_ack = state == DONE && grant == 2'd1;
    assign ss_ack  = state == DONE && grant == 2'd2;
    assign bk_ack  = state == DONE && grant == 2'd3;
    assign busy    = state != IDLE;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 2'd0;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            mem_di   <= 8'd0;
            wr       <= 1'b0;
            cpu_do   <= 8'd0;
            ss_do    <= 8'd0;
            bk_do    <= 8'd0;
            age      <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            mem_addr <= addr_n;
            mem_we   <= we_n;
            mem_di   <= di_n;
            wr       <= wr_n;
            cpu_do   <= cpu_do_n;
            ss_do    <= ss_do_n;
            bk_do    <= bk_do_n;
            age      <= age_n;
        end
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        addr_n   = mem_addr;
        we_n     = 1'b0;
        di_n     = mem_di;
        wr_n     = wr;
        cpu_do_n = cpu_do;
        ss_do_n  = ss_do;
        bk_do_n  = bk_do;
        age_n    = age;
        case (state)
            IDLE: begin
                if (win != 2'd0) begin
                    state_n = ISSUE;
                    grant_n = win;
                    addr_n  = win == 2'd1 ? cpu_addr : win == 2'd2 ? ss_addr : bk_addr;
                    wr_n    = win == 2'd1 ? cpu_we : win == 2'd2 ? ss_we : bk_we;
                    di_n    = win == 2'd1 ? cpu_di : win == 2'd2 ? ss_di : bk_di;
                    we_n    = wr_n;
                end
                age_n = (win == 2'd3 || !bk_req) ? '0 :
                        (win != 2'd0 && age != AGE_TOP) ? age + AW'(1) : age;
            end
            ISSUE: state_n = DONE;
            DONE: begin
                state_n  = IDLE;
                grant_n  = 2'd0;
                cpu_do_n = (!wr && grant == 2'd1) ? mem_q : cpu_do;
                ss_do_n  = (!wr && grant == 2'd2) ? mem_q : ss_do;
                bk_do_n  = (!wr && grant == 2'd3) ? mem_q : bk_do;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cram_access_arbiter.sv
// tb_cram_access_arbiter: directed scoreboard bench for cram_access_arbiter with a 1-cycle-latency RAM model
module tb_cram_access_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, ss_req = 0, ss_we = 0, bk_req = 0, bk_we = 0, ss_lock = 0;
    logic [16:0] cpu_addr = 0, ss_addr = 0, bk_addr = 0;
    logic [7:0]  cpu_di = 0, ss_di = 0, bk_di = 0;
    logic [7:0]  cpu_do, ss_do, bk_do, mem_di, mem_q;
    logic        cpu_ack, ss_ack, bk_ack, mem_we, busy;
    logic [16:0] mem_addr;
    logic [1:0]  grant;
    logic [7:0]  mem [0:(1<<17)-1];
    int          cyc = 0;
    int          n_run = 0;
    int          n_fail = 0;
    logic        keep_ss = 0, keep_bk = 0;

    typedef struct {
        logic [1:0] who;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t q[$];

    cram_access_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_ack(cpu_ack),
        .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr), .ss_di(ss_di), .ss_do(ss_do), .ss_ack(ss_ack),
        .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_di(bk_di), .bk_do(bk_do), .bk_ack(bk_ack),
        .ss_lock(ss_lock), .mem_addr(mem_addr), .mem_we(mem_we), .mem_di(mem_di), .mem_q(mem_q),
        .busy(busy), .grant(grant)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(posedge clk_sys) begin
        if (mem_we) mem[mem_addr] <= mem_di;
        mem_q <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] who, input logic [7:0] data, input int c);
        exp_t e;
        e.who = who;
        e.data = data;
        e.cyc = c;
        q.push_back(e);
    endtask

    // cycle label of the current sample point is cyc+1: a request driven now is sampled at edge cyc+1
    task automatic wait_ack();
        exp_t e;
        logic [1:0] who;
        logic [7:0] d;
        who = 2'd0;
        for (int k = 0; k < 40 && who == 2'd0; k++) begin
            @(posedge clk_sys); #1;
            who = cpu_ack ? 2'd1 : ss_ack ? 2'd2 : bk_ack ? 2'd3 : 2'd0;
        end
        if (q.size() == 0) begin
            n_run++; n_fail++;
            $error("FAIL scoreboard_empty: got ack %0d expected none", who);
            return;
        end
        e = q.pop_front();
        if (who == 2'd0) begin
            n_run++; n_fail++;
            $error("FAIL ack_timeout: got no ack expected requester %0d", e.who);
            return;
        end
        chk("ack_who", who, e.who);
        chk("ack_cycle", cyc + 1, e.cyc);
        if (who == 2'd1) cpu_req = 1'b0;
        if (who == 2'd2 && !keep_ss) ss_req = 1'b0;
        if (who == 2'd3 && !keep_bk) bk_req = 1'b0;
        @(posedge clk_sys); #1;
        d = e.who == 2'd1 ? cpu_do : e.who == 2'd2 ? ss_do : bk_do;
        chk("do_data", d, e.data);
    endtask

    initial begin
        #200000;
        $error("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        mem[17'h00010] = 8'h00;
        mem[17'h00100] = 8'h11;
        mem[17'h00200] = 8'h22;
        mem[17'h00300] = 8'h33;
        mem[17'h00400] = 8'h44;
        mem[17'h00500] = 8'h55;
        mem[17'h00600] = 8'h66;
        mem[17'h1FFFF] = 8'h3C;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem", {mem_we, mem_di, mem_addr}, 0);
        chk("rst_do", {cpu_do, ss_do, bk_do}, 0);
        chk("rst_ack", {cpu_ack, ss_ack, bk_ack}, 0);
        reset = 1'b0;

        // reset in the middle of a cpu write
        cpu_we = 1; cpu_addr = 17'h00010; cpu_di = 8'h5A; cpu_req = 1;
        @(posedge clk_sys); #1;
        chk("t1_issue_we", mem_we, 1);
        #2 reset = 1'b1;
        #1;
        chk("t1_we", mem_we, 0);
        chk("t1_busy", busy, 0);
        chk("t1_grant", grant, 0);
        chk("t1_ack", cpu_ack, 0);
        cpu_req = 0;
        @(posedge clk_sys); #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_sys); #1;
            chk("t1_noack", cpu_ack, 0);
        end
        chk("t1_mem", mem[17'h00010], 8'h00);

        // cpu write then back-to-back read of the same byte
        cpu_we = 1; cpu_addr = 17'h01234; cpu_di = 8'hA5; cpu_req = 1;
        push(2'd1, 8'h00, cyc + 3);
        @(posedge clk_sys); #1;
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 17'h01234);
        chk("t2_di", mem_di, 8'hA5);
        chk("t2_grant", grant, 1);
        chk("t2_busy", busy, 1);
        wait_ack();
        cpu_we = 0; cpu_req = 1;
        push(2'd1, 8'hA5, cyc + 3);
        wait_ack();

        // all three request together
        cpu_addr = 17'h00100; ss_addr = 17'h00200; bk_addr = 17'h00300;
        cpu_req = 1; ss_req = 1; bk_req = 1;
        push(2'd1, 8'h11, cyc + 3);
        push(2'd2, 8'h22, cyc + 6);
        push(2'd3, 8'h33, cyc + 9);
        for (int i = 0; i < 3; i++) wait_ack();

        // ss saturating traffic against a waiting bk
        ss_addr = 17'h00400; bk_addr = 17'h00500;
        ss_req = 1; bk_req = 1;
        for (int k = 0; k < 15; k++) push(2'd2, 8'h44, cyc + 3 + 3 * k);
        push(2'd3, 8'h55, cyc + 48);
        for (int k = 0; k < 15; k++) push(2'd2, 8'h44, cyc + 51 + 3 * k);
        push(2'd3, 8'h55, cyc + 96);
        for (int i = 0; i < 32; i++) begin
            keep_ss = i < 30;
            keep_bk = i < 31;
            wait_ack();
        end

        // ss_lock shuts out cpu until it drops
        ss_lock = 1; cpu_addr = 17'h00600; keep_ss = 1;
        cpu_req = 1; ss_req = 1;
        push(2'd2, 8'h44, cyc + 3);
        push(2'd2, 8'h44, cyc + 6);
        push(2'd2, 8'h44, cyc + 9);
        for (int i = 0; i < 3; i++) wait_ack();
        ss_lock = 0; keep_ss = 0;
        push(2'd1, 8'h66, cyc + 3);
        push(2'd2, 8'h44, cyc + 6);
        wait_ack();
        wait_ack();

        // bk read at the top byte of the address space
        bk_addr = 17'h1FFFF; bk_req = 1;
        push(2'd3, 8'h3C, cyc + 3);
        @(posedge clk_sys); #1;
        chk("t6_addr_issue", mem_addr, 17'h1FFFF);
        chk("t6_grant", grant, 3);
        chk("t6_we", mem_we, 0);
        wait_ack();
        chk("t6_cpu_do", cpu_do, 8'h66);
        chk("t6_ss_do", ss_do, 8'h44);
        chk("t6_addr", mem_addr, 17'h1FFFF);
        chk("t6_idle", {busy, grant}, 0);
        chk("sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
